// File: rtl/mutex_pkg.sv
// mutex_pkg: shared state encoding and defaults for the mutex requester
package mutex_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10,
    REL  = 2'b11
  } state_e;
  localparam int NUM_REQ_DEF = 5;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/mutex_req_chan.sv
// mutex_req_chan: one requester channel (grant synchronizer, 4-phase handshake FSM, hold/wait counters, arming)
module mutex_req_chan import mutex_pkg::*; #(
  parameter int HOLD_W = 8,
  parameter int SYNC_STAGES = SYNC_DEPTH,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              grant,
  output logic              req,
  output logic              busy,
  output logic              done,
  output logic              in_hold,
  output logic              spur,
  output logic              to_hit
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [SYNC_STAGES-1:0] sync_q, prime_q;
  logic armed_q, req_q, req_d, done_q, done_d, gs;
  assign gs = sync_q[SYNC_STAGES-1];
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    wait_d = wait_q;
    req_d = req_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        req_d = 1'b1;
        wait_d = '0;
        hold_d = (hold_len == '0) ? HOLD_W'(1) : hold_len;
      end
      REQ: begin
        wait_d = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + WAIT_W'(1);
        state_d = gs ? HOLD : REQ;
      end
      HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        state_d = (hold_q == HOLD_W'(1)) ? REL : HOLD;
        req_d = (hold_q != HOLD_W'(1));
      end
      REL: begin
        state_d = gs ? REL : IDLE;
        done_d = ~gs;
      end
    endcase
  end
  // prime_q marks when gs reflects a real post-reset sample, so reset-cleared flops can't arm the channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q <= '0;
      wait_q <= '0;
      req_q <= 1'b0;
      done_q <= 1'b0;
      sync_q <= '0;
      prime_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      wait_q <= wait_d;
      req_q <= req_d;
      done_q <= done_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], grant};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      armed_q <= armed_q | (prime_q[SYNC_STAGES-1] & ~gs);
    end
  end
  assign req = req_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign in_hold = (state_q == HOLD);
  assign spur = (state_q == IDLE) && armed_q && gs;
  assign to_hit = (state_q == REQ) && (wait_q == WAIT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mutex_requester5.sv
// mutex_requester5: five-channel requester for a mutex arbiter with exclusion and timeout checking
module mutex_requester5 import mutex_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int HOLD_W = 8,
  parameter int SYNC_STAGES = SYNC_DEPTH,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        start,
  input  logic [NUM_REQ*HOLD_W-1:0] hold_len,
  output logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        busy,
  output logic [NUM_REQ-1:0]        done,
  output logic                      excl_err,
  output logic [NUM_REQ-1:0]        timeout_err
);
  logic [NUM_REQ-1:0] in_hold, spur, to_hit, timeout_q, timeout_d;
  logic excl_err_q, excl_err_d, overlap;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
    mutex_req_chan #(
      .HOLD_W(HOLD_W),
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT(TIMEOUT)
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .start(start[g]),
      .hold_len(hold_len[g*HOLD_W +: HOLD_W]),
      .grant(grant[g]),
      .req(req[g]),
      .busy(busy[g]),
      .done(done[g]),
      .in_hold(in_hold[g]),
      .spur(spur[g]),
      .to_hit(to_hit[g])
    );
  end
  // clearing the lowest set bit leaves something only if two or more channels hold
  assign overlap = |(in_hold & (in_hold - NUM_REQ'(1)));
  assign excl_err_d = excl_err_q | overlap | (|spur);
  assign timeout_d = timeout_q | to_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      excl_err_q <= 1'b0;
      timeout_q <= '0;
    end else begin
      excl_err_q <= excl_err_d;
      timeout_q <= timeout_d;
    end
  end
  assign excl_err = excl_err_q;
  assign timeout_err = timeout_q;
endmodule

// File: tb/tb_mutex_requester5.sv
// tb_mutex_requester5: directed bench with a behavioural mutex arbiter
module tb_mutex_requester5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] start = '0;
  logic [39:0] hold_len = '0;
  logic [4:0] req, grant, busy, done, timeout_err;
  logic excl_err;
  logic [4:0] arb_g = '0;
  logic [4:0] ovr_en = '0;
  logic [4:0] ovr_val = '0;
  int passed = 0;
  int total = 0;

  mutex_requester5 #(.NUM_REQ(5), .HOLD_W(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold_len(hold_len), .req(req),
    .grant(grant), .busy(busy), .done(done), .excl_err(excl_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // mutex arbiter: releases on request drop, then grants the lowest requester when free
  always @(negedge clk) begin : arb
    logic [4:0] g;
    g = arb_g & req;
    for (int i = 0; i < 5; i++) if (req[i] && g == '0) g[i] = 1'b1;
    arb_g <= g;
  end
  assign grant = (ovr_en & ovr_val) | (~ovr_en & arb_g);

  typedef struct {int ch; int h; int lat; int reqc;} vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = '0;
    ovr_en = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic launch(input int ch, input int h);
    hold_len = '0;
    hold_len[ch*8 +: 8] = 8'(h);
    start = '0;
    start[ch] = 1'b1;
    tick();
    start = '0;
  endtask

  initial begin
    int lat, reqc, dones, busy_at_done, busy0, dt[5], ndone, busy_after;
    vecs[0] = '{0, 4, 10, 7};
    vecs[1] = '{1, 1, 7, 4};
    vecs[2] = '{2, 0, 7, 4};
    vecs[3] = '{3, 10, 16, 13};
    vecs[4] = '{4, 255, 261, 258};
    vecs[5] = '{4, 0, 7, 4};
    do_reset();
    chk("rst_req", int'(req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_excl", int'(excl_err), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    for (int v = 0; v < 6; v++) begin
      launch(vecs[v].ch, vecs[v].h);
      lat = -1; reqc = 0; dones = 0; busy_at_done = -1;
      busy0 = int'(busy[vecs[v].ch]);
      for (int n = 0; n < 300; n++) begin
        if (req[vecs[v].ch]) reqc++;
        if (done[vecs[v].ch]) begin
          dones++;
          if (lat < 0) begin lat = n; busy_at_done = int'(busy[vecs[v].ch]); end
        end
        tick();
      end
      chk($sformatf("vec%0d_busy_start", v), busy0, 1);
      chk($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("vec%0d_req_cycles", v), reqc, vecs[v].reqc);
      chk($sformatf("vec%0d_done_pulses", v), dones, 1);
      chk($sformatf("vec%0d_busy_at_done", v), busy_at_done, 0);
      chk($sformatf("vec%0d_excl", v), int'(excl_err), 0);
    end
    // all five at once: grants serialize six cycles apart; the last two wait past TIMEOUT
    do_reset();
    hold_len = {5{8'd3}};
    start = 5'h1f;
    tick();
    start = '0;
    for (int i = 0; i < 5; i++) dt[i] = -1;
    ndone = 0;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 5; i++) if (done[i]) begin ndone++; if (dt[i] < 0) dt[i] = n; end
      tick();
    end
    for (int i = 0; i < 5; i++) chk($sformatf("all5_done_ch%0d", i), dt[i], 9 + 6 * i);
    chk("all5_done_count", ndone, 5);
    chk("all5_excl", int'(excl_err), 0);
    chk("all5_timeout", int'(timeout_err), 5'b11000);
    // spurious grant on an armed idle channel
    do_reset();
    for (int n = 0; n < 6; n++) tick();
    chk("spur_before", int'(excl_err), 0);
    ovr_en[2] = 1'b1; ovr_val[2] = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    chk("spur_set", int'(excl_err), 1);
    ovr_en = '0;
    for (int n = 0; n < 10; n++) tick();
    chk("spur_sticky", int'(excl_err), 1);
    do_reset();
    chk("spur_cleared", int'(excl_err), 0);
    // timeout on channel 1 with grant held low, then normal completion
    ovr_en[1] = 1'b1; ovr_val[1] = 1'b0;
    launch(1, 2);
    for (int n = 0; n <= 16; n++) begin
      if (n == 15) chk("to_n15", int'(timeout_err[1]), 0);
      if (n == 16) chk("to_n16", int'(timeout_err[1]), 1);
      if (n < 16) tick();
    end
    ovr_en = '0;
    lat = -1;
    for (int n = 0; n < 50 && lat < 0; n++) begin
      tick();
      if (done[1]) lat = n;
    end
    chk("to_done_seen", int'(lat >= 0), 1);
    chk("to_flags", int'(timeout_err), 5'b00010);
    chk("to_excl", int'(excl_err), 0);
    // reset during HOLD on channel 3 with grant still high across reset release
    do_reset();
    launch(3, 20);
    for (int n = 0; n < 5; n++) tick();
    chk("midrst_req_before", int'(req[3]), 1);
    rst_n = 1'b0;
    ovr_en[3] = 1'b1; ovr_val[3] = 1'b1;
    #1;
    chk("midrst_req_drop", int'(req), 0);
    chk("midrst_busy_drop", int'(busy), 0);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    ovr_en = '0;
    for (int n = 0; n < 8; n++) tick();
    chk("midrst_excl", int'(excl_err), 0);
    launch(3, 2);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (done[3] && lat < 0) lat = n;
      tick();
    end
    chk("midrst_restart_latency", lat, 8);
    // hold_len 0 on channel 4 with a start pulse landing in REL
    launch(4, 0);
    lat = -1; reqc = 0; busy_after = 0;
    for (int n = 0; n < 30; n++) begin
      if (n == 5) begin
        chk("rel_busy", int'(busy[4]), 1);
        chk("rel_req", int'(req[4]), 0);
        start[4] = 1'b1;
      end
      if (n == 6) start = '0;
      if (req[4]) reqc++;
      if (done[4] && lat < 0) lat = n;
      if (lat >= 0 && n > lat && busy[4]) busy_after++;
      tick();
    end
    chk("h0_latency", lat, 7);
    chk("h0_req_cycles", reqc, 4);
    chk("h0_rel_start_ignored", busy_after, 0);
    chk("h0_excl", int'(excl_err), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mutex_requester5.md
# mutex_requester5

Synchronous requester-side controller for the 5-way mutex arbiter (`Arbiter_5`, ports X4..X0 / Y4..Y0). Each of five channels runs a 4-phase req/grant handshake against the arbiter. A channel accepts a start pulse, raises its request, and waits for the asynchronous grant through a synchronizer. It then holds the grant for a programmed number of cycles, releases, and waits for the grant to fall. The block also checks mutual exclusion and request timeouts, so the arbiter can be exercised and checked from clocked logic.

## Interface
- NUM_REQ, 5, number of channels; must match the arbiter width.
- HOLD_W, 8, width of each per-channel hold length.
- SYNC_STAGES, 2, flip-flop depth of the grant synchronizer (minimum 2).
- TIMEOUT, 255, REQ-state wait cycles before timeout_err is set.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  NUM_REQ  per-channel one-cycle request pulse.
- hold_len  in  NUM_REQ*HOLD_W  per-channel hold cycles; channel i uses bits [i*HOLD_W +: HOLD_W]. Sampled when start is accepted.
- req  out  NUM_REQ  registered request to arbiter X[i].
- grant  in  NUM_REQ  asynchronous grant from arbiter Y[i].
- busy  out  NUM_REQ  channel is not IDLE.
- done  out  NUM_REQ  one-cycle pulse when a handshake completes.
- excl_err  out  1  sticky mutual-exclusion or spurious-grant error.
- timeout_err  out  NUM_REQ  sticky per-channel timeout.

## Operation
- Synchronizer: gs[i] = grant[i] after SYNC_STAGES flops. All FSM decisions use gs only.
- Per-channel FSM states: IDLE, REQ, HOLD, REL.
- IDLE:
  - If start[i]=1, latch hold_len (value 0 is treated as 1), set req[i]=1, clear the wait counter, go to REQ.
  - If start[i]=0, remain in IDLE.
- REQ:
  - req[i]=1. The wait counter increments each cycle and saturates.
  - When the counter reaches TIMEOUT, set timeout_err[i]. Keep waiting; the request is never withdrawn before grant.
  - If gs[i]=1, load the hold counter and go to HOLD.
- HOLD:
  - req[i]=1. The hold counter decrements each cycle.
  - When it reaches 0, set req[i]=0 and go to REL.
- REL: req[i]=0. When gs[i]=0, pulse done[i] and go to IDLE.
- start[i] is ignored in any state other than IDLE. start on several channels in the same cycle is legal; channels run independently.
- excl_err sets on either condition:
  - More than one channel in HOLD in the same cycle.
  - gs[i]=1 while channel i is IDLE and armed.
- A channel arms after reset once gs[i] has been observed 0. This masks grants still falling from a reset mid-handshake.
- excl_err and timeout_err clear only on reset.
- Reset values: every state IDLE, req=0, busy=0, done=0, excl_err=0, timeout_err=0, counters 0, synchronizer flops 0, channels unarmed.
- Reset mid-operation drops req immediately (asynchronous). The arbiter then releases on its own.

## Timing
- Edge k samples start[i]=1. req[i]=1 and busy[i]=1 are visible after edge k.
- Arbiter grant rises asynchronously. gs[i] follows within SYNC_STAGES to SYNC_STAGES+1 cycles.
- The edge that first sees gs[i]=1 enters HOLD. req stays high for exactly H further cycles (H = max(hold_len,1)), then drops.
- done[i] is high for exactly the one cycle after the edge that first sees gs[i]=0 in REL. busy[i] falls with done.
- Minimum start-to-done with an ideal arbiter: 1 + 2·SYNC_STAGES + H cycles, plus arbiter delay.
- A new start is accepted in the first IDLE cycle, i.e. the cycle done is high.

## Structure
- Shared package mutex_pkg holds:
  - State encodings: IDLE=2'b00, REQ=2'b01, HOLD=2'b10, REL=2'b11.
  - NUM_REQ default.
  - Synchronizer depth constant.
- Natural sub-module mutex_req_chan: one channel's synchronizer, FSM, hold and wait counters, and armed flag. It is generated NUM_REQ times.
- The top level holds the HOLD-overlap check (more than one channel in HOLD), the excl_err/timeout_err flags, and the port slicing.

## Test plan
- Single channel: start[0] with hold_len[0]=4, arbiter connected -> req[0] high for 1+2+2+4 cycles region. done[0] is a single pulse, excl_err=0.
- All five channels started in the same cycle, hold_len=3 each -> five sequential grants, never two channels in HOLD, five done pulses, excl_err=0.
- Grant forced high on channel 2 while IDLE, after gs has been seen 0 -> excl_err=1 and stays 1 until reset.
- Grant held low on channel 1 after start, TIMEOUT=16 -> timeout_err[1]=1 at the 16th REQ cycle. Releasing the grant afterwards completes normally with done[1].
- Reset asserted during HOLD on channel 3 -> req=0 immediately. After reset, the still-falling grant does not set excl_err, and a new start[3] completes.
- hold_len=0 on channel 4 -> behaves as H=1. start[4] pulsed during REL is ignored.
